// File: rtl/alu_seq_muldiv.sv
// Sequential EX-stage ALU: single-cycle base ops plus iterative RV32M multiply/divide behind a
// valid/ready handshake. Define ALU_ZERO_SKIP_EN to let trivial mul/div cases finish in one cycle.
module alu_seq_muldiv #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     busy
);
  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CntLast = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q;
  logic [W-1:0]    acc_q, lo_q, opnd_q, result_q;
  logic [1:0]      op_q;
  logic            neg_q, rneg_q;

  // Operand decode
  logic [2:0]      func;
  logic            is_m, is_div, a_signed, b_signed, a_neg, b_neg, b_zero, accept;
  logic [W-1:0]    a_mag, b_mag;
  logic [CW-1:0]   shamt;
  logic [W-1:0]    base_res;
  logic            skip;
  logic [W-1:0]    skip_res;

  assign func     = Operation[2:0];
  assign is_m     = Operation[4] & ~Operation[3];
  assign is_div   = is_m & Operation[2];
  assign a_signed = (func == 3'b001) | (func == 3'b010) | (func == 3'b100) | (func == 3'b110);
  assign b_signed = (func == 3'b001) | (func == 3'b100) | (func == 3'b110);
  assign a_neg    = a_signed & SrcA[W-1];
  assign b_neg    = b_signed & SrcB[W-1];
  assign a_mag    = a_neg ? -SrcA : SrcA;
  assign b_mag    = b_neg ? -SrcB : SrcB;
  assign b_zero   = (SrcB == '0);
  assign shamt    = SrcB[CW-1:0];
  assign accept   = in_valid & in_ready & ~flush;

  always_comb begin
    base_res = '0;
    if (!Operation[4]) begin
      case (Operation[3:0])
        4'b0000: base_res = SrcA & SrcB;
        4'b0001: base_res = SrcA ^ SrcB;
        4'b0010: base_res = SrcA | SrcB;
        4'b0011: base_res = SrcA + SrcB;
        4'b0100: base_res = SrcA - SrcB;
        4'b0101: base_res = W'(SrcA == SrcB);
        4'b0110: base_res = W'(SrcA != SrcB);
        4'b0111: base_res = W'($signed(SrcA) < $signed(SrcB));
        4'b1000: base_res = W'($signed(SrcA) >= $signed(SrcB));
        4'b1001: base_res = SrcA >> shamt;
        4'b1010: base_res = SrcA << shamt;
        4'b1011: base_res = $signed(SrcA) >>> shamt;
        4'b1100: base_res = SrcB;
        4'b1111: base_res = W'(1);
        default: base_res = '0;
      endcase
    end
  end

`ifdef ALU_ZERO_SKIP_EN
  always_comb begin
    skip     = 1'b0;
    skip_res = '0;
    if (is_m && !is_div && (SrcA == '0 || b_zero)) begin
      skip = 1'b1;
    end else if (is_div && b_zero) begin
      skip     = 1'b1;
      skip_res = func[1] ? SrcA : '1;
    end else if (is_div && func[0] && (SrcA < SrcB)) begin
      skip     = 1'b1;
      skip_res = func[1] ? SrcA : '0;
    end
  end
`else
  assign skip     = 1'b0;
  assign skip_res = '0;
`endif

  // One shift-add multiply step: {acc_q, lo_q} holds partial product over remaining multiplier.
  logic [W:0]     mul_sum;
  logic [W-1:0]   mul_acc, mul_lo;
  logic [2*W-1:0] mul_prod, mul_fix;
  logic [W-1:0]   mul_res;
  assign mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_acc  = mul_sum[W:1];
  assign mul_lo   = {mul_sum[0], lo_q[W-1:1]};
  assign mul_prod = {mul_acc, mul_lo};
  assign mul_fix  = neg_q ? -mul_prod : mul_prod;
  assign mul_res  = (op_q == 2'b00) ? mul_fix[W-1:0] : mul_fix[2*W-1:W];

  // One restoring divide step: acc_q is the partial remainder, lo_q shifts dividend out/quotient in.
  logic [W:0]     div_shift, div_trial;
  logic           div_ok;
  logic [W-1:0]   div_acc, div_lo, quo_fix, rem_fix, div_res;
  assign div_shift = {acc_q, lo_q[W-1]};
  assign div_trial = div_shift - {1'b0, opnd_q};
  assign div_ok    = ~div_trial[W];
  assign div_acc   = div_ok ? div_trial[W-1:0] : div_shift[W-1:0];
  assign div_lo    = {lo_q[W-2:0], div_ok};
  assign quo_fix   = neg_q ? -lo_q : lo_q;
  assign rem_fix   = rneg_q ? -acc_q : acc_q;
  assign div_res   = op_q[1] ? rem_fix : quo_fix;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: if (accept) state_d = (!is_m || skip) ? StDone : (is_div ? StDiv : StMul);
        StMul:  if (count_q == CntLast) state_d = StDone;
        StDiv:  if (count_q == CntLast) state_d = StFix;
        StFix:  state_d = StDone;
        StDone: if (out_ready) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      StIdle:              in_ready  = 1'b1;
      StMul, StDiv, StFix: busy      = 1'b1;
      StDone:              out_valid = 1'b1;
      default: ;
    endcase
  end

  assign ALUResult = result_q;

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            count_q <= '0;
            acc_q   <= '0;
            op_q    <= func[1:0];
            opnd_q  <= is_div ? b_mag : a_mag;
            lo_q    <= is_div ? a_mag : b_mag;
            // Divide-by-zero keeps the all-ones quotient unsigned-looking.
            neg_q   <= is_div ? ((a_neg ^ b_neg) & ~b_zero) : (a_neg ^ b_neg);
            rneg_q  <= a_neg;
            if (!is_m)     result_q <= base_res;
            else if (skip) result_q <= skip_res;
          end
        end
        StMul: begin
          acc_q   <= mul_acc;
          lo_q    <= mul_lo;
          count_q <= (count_q == CntLast) ? '0 : count_q + CW'(1);
          if (count_q == CntLast) result_q <= mul_res;
        end
        StDiv: begin
          acc_q   <= div_acc;
          lo_q    <= div_lo;
          count_q <= (count_q == CntLast) ? '0 : count_q + CW'(1);
        end
        StFix: result_q <= div_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Self-checking bench for alu_seq_muldiv: scoreboard of model/constant expectations per scenario.
module tb_alu_seq_muldiv;
  localparam int W = 32;
`ifdef ALU_ZERO_SKIP_EN
  localparam bit Skip = 1'b1;
`else
  localparam bit Skip = 1'b0;
`endif

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        flush     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] SrcA      = '0;
  logic [31:0] SrcB      = '0;
  logic [4:0]  Operation = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] ALUResult;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];
  logic [31:0] last_res = '0;

  always #5 clk = ~clk;

  alu_seq_muldiv #(.DATA_WIDTH(32), .OPCODE_LENGTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .out_valid(out_valid),
    .out_ready(out_ready), .ALUResult(ALUResult), .busy(busy)
  );

  function automatic logic [31:0] model(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    logic signed [63:0] ps;
    logic [63:0]        pu;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      5'h00: return a & b;
      5'h01: return a ^ b;
      5'h02: return a | b;
      5'h03: return a + b;
      5'h04: return a - b;
      5'h05: return {31'b0, a == b};
      5'h06: return {31'b0, a != b};
      5'h07: return {31'b0, sa < sb};
      5'h08: return {31'b0, sa >= sb};
      5'h09: return a >> b[4:0];
      5'h0A: return a << b[4:0];
      5'h0B: return sa >>> b[4:0];
      5'h0C: return b;
      5'h0F: return 32'd1;
      5'h10: return a * b;
      5'h11: begin
        ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return ps[63:32];
      end
      5'h12: begin
        pu = {{32{a[31]}}, a} * {32'b0, b};
        return pu[63:32];
      end
      5'h13: begin
        pu = {32'b0, a} * {32'b0, b};
        return pu[63:32];
      end
      5'h14: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      5'h15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'h16: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      5'h17: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    if (!op[4] || op[3]) return 1;
    if (!op[2]) return (Skip && (a == 0 || b == 0)) ? 1 : W + 1;
    if (Skip && (b == 0 || (op[0] && a < b))) return 1;
    return W + 2;
  endfunction

  // Drives one op from an idle DUT, returns its result and edges from accept to out_valid.
  task automatic issue_and_wait(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output int lat);
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = ALUResult;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid);
    end
    checks++;
    if (ALUResult !== 32'd0) begin
      errors++; $display("FAIL reset_result got %h exp 0", ALUResult);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b exp 0", busy);
    end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_base_ops();
    logic [31:0] pa [3];
    logic [31:0] pb [3];
    logic [4:0]  op;
    logic [31:0] res, e;
    int          lat, el;
    pa = '{32'd7, 32'h8000_0000, 32'h1234_5678};
    pb = '{32'hFFFF_FFFD, 32'd4, 32'h1234_5678};
    for (int k = 0; k < 18; k++) begin
      op = (k < 16) ? 5'(k) : ((k == 16) ? 5'h18 : 5'h1F);
      for (int p = 0; p < 3; p++) begin
        exp_q.push_back(model(op, pa[p], pb[p]));
        lat_q.push_back(exp_lat(op, pa[p], pb[p]));
        issue_and_wait(op, pa[p], pb[p], res, lat);
        e  = exp_q.pop_front();
        el = lat_q.pop_front();
        checks++;
        if (res !== e) begin
          errors++;
          $display("FAIL base op=%h a=%h b=%h got %h exp %h", op, pa[p], pb[p], res, e);
        end
        checks++;
        if (lat != el) begin
          errors++; $display("FAIL base_latency op=%h got %0d exp %0d", op, lat, el);
        end
        last_res = e;
      end
    end
  endtask

  task automatic test_spec_vectors();
    logic [4:0]  vop [16];
    logic [31:0] va  [16];
    logic [31:0] vb  [16];
    logic [31:0] ve  [16];
    logic [31:0] res, e;
    int          lat, el;
    vop = '{5'h03, 5'h0B, 5'h10, 5'h11, 5'h13, 5'h12, 5'h14, 5'h16,
            5'h14, 5'h16, 5'h15, 5'h17, 5'h14, 5'h16, 5'h15, 5'h17};
    va  = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5,
            32'd5, 32'hFFFF_FFFB, 32'd3, 32'd3};
    vb  = '{32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0,
            32'd0, 32'd0, 32'd9, 32'd9};
    ve  = '{32'd4, 32'hF800_0000, 32'd1, 32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
            32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd5,
            32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'd0, 32'd3};
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(ve[i]);
      lat_q.push_back(exp_lat(vop[i], va[i], vb[i]));
      issue_and_wait(vop[i], va[i], vb[i], res, lat);
      e  = exp_q.pop_front();
      el = lat_q.pop_front();
      checks++;
      if (res !== e) begin
        errors++; $display("FAIL vector%0d op=%h got %h exp %h", i, vop[i], res, e);
      end
      checks++;
      if (lat != el) begin
        errors++; $display("FAIL vector%0d_latency got %0d exp %0d", i, lat, el);
      end
      last_res = e;
    end
    // Zero multiplicand exercises the skip path when enabled
    exp_q.push_back(32'd0);
    lat_q.push_back(exp_lat(5'h11, 32'd0, 32'd5));
    issue_and_wait(5'h11, 32'd0, 32'd5, res, lat);
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    checks++;
    if (res !== e || lat != el) begin
      errors++; $display("FAIL mulh_zero got %h/%0d exp %h/%0d", res, lat, e, el);
    end
    last_res = e;
  endtask

  task automatic test_muldiv_random();
    logic [31:0] a, b, res, e;
    logic [4:0]  op;
    int          lat, el;
    for (int i = 0; i < 32; i++) begin
      op = 5'h10 + 5'(i % 8);
      a  = $urandom;
      b  = (i % 5 == 4) ? 32'(($urandom % 13) + 1) : $urandom;
      exp_q.push_back(model(op, a, b));
      lat_q.push_back(exp_lat(op, a, b));
      issue_and_wait(op, a, b, res, lat);
      e  = exp_q.pop_front();
      el = lat_q.pop_front();
      checks++;
      if (res !== e) begin
        errors++; $display("FAIL muldiv op=%h a=%h b=%h got %h exp %h", op, a, b, res, e);
      end
      checks++;
      if (lat != el) begin
        errors++; $display("FAIL muldiv_latency op=%h got %0d exp %0d", op, lat, el);
      end
      last_res = e;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    exp_q.push_back(32'd123);
    Operation = 5'h03; SrcA = 32'd100; SrcB = 32'd23;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || ALUResult !== e) begin
        errors++;
        $display("FAIL backpressure cyc%0d got v=%b r=%b res=%h exp v=1 r=0 res=%h",
                 i, out_valid, in_ready, ALUResult, e);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || ALUResult !== e) begin
      errors++;
      $display("FAIL backpressure_release got v=%b r=%b res=%h exp v=0 r=1 res=%h",
               out_valid, in_ready, ALUResult, e);
    end
    last_res = e;
  endtask

  task automatic test_flush_div();
    int          seen;
    logic [31:0] res, e;
    int          lat, el;
    Operation = 5'h14; SrcA = 32'd1000; SrcB = 32'd7;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL flush_pre_busy got %b exp 1", busy);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_state got r=%b busy=%b v=%b exp r=1 busy=0 v=0",
               in_ready, busy, out_valid);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0 || ALUResult !== last_res) begin
      errors++;
      $display("FAIL flush_discard got valid_cycles=%0d res=%h exp 0 res=%h",
               seen, ALUResult, last_res);
    end
    // Next divide must run its full length from a cleared count
    exp_q.push_back(model(5'h15, 32'd1000, 32'd7));
    lat_q.push_back(exp_lat(5'h15, 32'd1000, 32'd7));
    issue_and_wait(5'h15, 32'd1000, 32'd7, res, lat);
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    checks++;
    if (res !== e || lat != el) begin
      errors++; $display("FAIL flush_recover got %h/%0d exp %h/%0d", res, lat, e, el);
    end
    last_res = e;
  endtask

  task automatic test_flush_accept();
    Operation = 5'h03; SrcA = 32'd1; SrcB = 32'd1;
    in_valid  = 1'b1;
    flush     = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_accept got v=%b r=%b busy=%b exp v=0 r=1 busy=0",
               out_valid, in_ready, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || ALUResult !== last_res) begin
      errors++;
      $display("FAIL flush_accept_late got v=%b res=%h exp v=0 res=%h",
               out_valid, ALUResult, last_res);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    exp_q.push_back(32'd30);
    exp_q.push_back(32'd12);
    Operation = 5'h03; SrcA = 32'd10; SrcB = 32'd20;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || ALUResult !== e) begin
      errors++; $display("FAIL b2b_first got v=%b res=%h exp v=1 res=%h", out_valid, ALUResult, e);
    end
    // Second op is presented during the first result's handshake
    Operation = 5'h04; SrcA = 32'd20; SrcB = 32'd8;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_gap got r=%b v=%b exp r=1 v=0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || ALUResult !== e) begin
      errors++; $display("FAIL b2b_second got v=%b res=%h exp v=1 res=%h", out_valid, ALUResult, e);
    end
    @(posedge clk); #1;
    last_res = e;
  endtask

  task automatic test_reset_mid_op();
    Operation = 5'h10; SrcA = 32'd3; SrcB = 32'd5;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    checks++;
    if (busy !== 1'b1 || ALUResult !== last_res) begin
      errors++;
      $display("FAIL midop_pre got busy=%b res=%h exp busy=1 res=%h", busy, ALUResult, last_res);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || ALUResult !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset got v=%b r=%b res=%h busy=%b exp v=0 r=1 res=0 busy=0",
               out_valid, in_ready, ALUResult, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_base_ops();
    test_spec_vectors();
    test_muldiv_random();
    test_backpressure();
    test_flush_div();
    test_flush_accept();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
